// File: rtl/sonic_pause_pkg.sv
// Shared types and constants for the 10G MAC pause-frame scheduler.
package sonic_pause_pkg;

  localparam int unsigned QUANTA_W_DEF  = 16;
  localparam int unsigned REFRESH_W_DEF = 16;
  localparam int unsigned XON_QUANTA    = 0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    XOFF_SEND = 3'd1,
    XOFF_HOLD = 3'd2,
    XON_SEND  = 3'd3,
    SW_SEND   = 3'd4
  } pause_state_e;

endpackage

// File: rtl/sonic_v1_15_pause_refresh_timer.sv
// XOFF refresh down-counter: load, decrement, registered zero flag.
module sonic_v1_15_pause_refresh_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic         zero_q;

  // Load wins over decrement; the zero flag tracks the count it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      zero_q  <= 1'b1;
    end else if (load_i) begin
      count_q <= load_val_i;
      zero_q  <= (load_val_i == '0);
    end else if (dec_i && !zero_q) begin
      count_q <= count_q - W'(1);
      zero_q  <= (count_q == W'(1));
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/sonic_v1_15_pcs_eth_10g_mac_pause_scheduler.sv
// Pause scheduler: arbitrates hardware XOFF/XON and software pause requests
// into a single Avalon-ST pause-length stream for the TX timing adapter.
module sonic_v1_15_pcs_eth_10g_mac_pause_scheduler
  import sonic_pause_pkg::*;
#(
  parameter int unsigned QUANTA_W  = QUANTA_W_DEF,
  parameter int unsigned REFRESH_W = REFRESH_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_enable,
  input  logic [QUANTA_W-1:0]  cfg_pause_quanta,
  input  logic [REFRESH_W-1:0] cfg_refresh_interval,
  input  logic                 hw_xoff_req,
  input  logic                 sw_pause_req,
  input  logic [QUANTA_W-1:0]  sw_pause_quanta,
  output logic                 sw_ack,
  output logic                 out_valid,
  output logic [QUANTA_W-1:0]  out_data,
  input  logic                 out_ready,
  output logic                 xoff_active,
  output logic [15:0]          pause_sent_cnt
);

  pause_state_e        state_q;
  logic                out_valid_q;
  logic [QUANTA_W-1:0] out_data_q;
  logic                sw_ack_q;
  logic                xoff_active_q;
  logic [15:0]         pause_cnt_q;
  logic [15:0]         pause_cnt_d;
  logic                sw_pend_q;
  logic [QUANTA_W-1:0] sw_quanta_q;

  logic hw_on;
  logic accept;
  logic tmr_load;
  logic tmr_dec;
  logic tmr_zero;

  assign hw_on    = cfg_enable & hw_xoff_req;
  assign accept   = out_valid_q & out_ready;
  assign tmr_load = (state_q == XOFF_SEND) & accept;
  assign tmr_dec  = (state_q == XOFF_HOLD) & hw_on & ~tmr_zero;

  sonic_v1_15_pause_refresh_timer #(
    .W (REFRESH_W)
  ) u_refresh_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (cfg_refresh_interval),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Software request latch: a new request always wins over the clear on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_pend_q   <= 1'b0;
      sw_quanta_q <= '0;
    end else if (sw_pause_req) begin
      sw_pend_q   <= 1'b1;
      sw_quanta_q <= sw_pause_quanta;
    end else if ((state_q == SW_SEND) && accept) begin
      sw_pend_q   <= 1'b0;
    end
  end

  // Scheduler FSM; valid/data are loaded on state entry and held until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      sw_ack_q      <= 1'b0;
      xoff_active_q <= 1'b0;
    end else begin
      sw_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hw_on) begin
            state_q       <= XOFF_SEND;
            out_valid_q   <= 1'b1;
            out_data_q    <= cfg_pause_quanta;
            xoff_active_q <= 1'b1;
          end else if (sw_pend_q) begin
            state_q     <= SW_SEND;
            out_valid_q <= 1'b1;
            out_data_q  <= sw_pause_req ? sw_pause_quanta : sw_quanta_q;
          end
        end
        XOFF_SEND: begin
          if (accept) begin
            state_q     <= XOFF_HOLD;
            out_valid_q <= 1'b0;
          end
        end
        XOFF_HOLD: begin
          if (!hw_on) begin
            state_q       <= XON_SEND;
            out_valid_q   <= 1'b1;
            out_data_q    <= QUANTA_W'(XON_QUANTA);
            xoff_active_q <= 1'b0;
          end else if (tmr_zero) begin
            state_q     <= XOFF_SEND;
            out_valid_q <= 1'b1;
            out_data_q  <= cfg_pause_quanta;
          end
        end
        XON_SEND: begin
          if (accept) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        SW_SEND: begin
          if (accept) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            sw_ack_q    <= 1'b1;
          end
        end
        default: begin
          state_q       <= IDLE;
          out_valid_q   <= 1'b0;
          xoff_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign pause_cnt_d = pause_cnt_q + 16'd1;

  // Accepted-transfer counter, free-running wrap at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      pause_cnt_q <= '0;
    end else if (accept) begin
      pause_cnt_q <= pause_cnt_d;
    end
  end

  assign sw_ack         = sw_ack_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign xoff_active    = xoff_active_q;
  assign pause_sent_cnt = pause_cnt_q;

endmodule
